mnist_s_pixel_frame_buffer: RTL and testbench
=============================================

Name: mnist_s_pixel_frame_buffer

Overview:
- Upstream input stage of the mnist_s ensemble, directly feeding the layer-0 neuron LUTs.
- Accepts a serial stream of 8-bit MNIST pixels over a valid/ready handshake and binarizes each pixel against a threshold.
- Packs each frame into a NUM_PIXELS-bit vector held in a ping-pong (two-bank) buffer.
- Presents completed frames with a valid/ready handshake; the layer-0 fan-in wiring slices 8-bit groups from out_data.

Parameters:
- NUM_PIXELS, 784, pixels per frame; bit i of out_data is pixel i in arrival order.
- PIX_W, 8, input pixel width.
- THRESH, 128, binarization threshold: bit = 1 iff pixel >= THRESH (unsigned).
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_pixel  in  PIX_W  unsigned pixel value.
- in_last  in  1  marks final pixel of a frame.
- out_valid  out  1  out_data holds a complete frame.
- out_ready  in  1  downstream consumes frame.
- out_data  out  NUM_PIXELS  binarized frame (read bank).
- frame_count  out  CNT_W  frames delivered; wraps modulo 2^CNT_W.
- drop_count  out  8  malformed frames dropped; saturates at 255.
- err_pulse  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset: in_ready=1, out_valid=0, out_data=0, frame_count=0, drop_count=0, err_pulse=0. Both banks empty, wr_bank=rd_bank=0, pixel index idx=0, write FSM in FILL.
- Beat accepted iff in_valid && in_ready.
- Write FSM has two states:
  - FILL: in_ready = write bank empty. Each accepted beat writes bit idx of the write bank with (in_pixel >= THRESH), then idx increments.
    - Accepted beat with idx==NUM_PIXELS-1 and in_last=1: write bank marked full, wr_bank toggles, idx=0.
    - Accepted beat with in_last=1 and idx<NUM_PIXELS-1 (short frame): frame dropped, idx=0, bank stays empty, err_pulse=1 next cycle, drop_count += 1 (saturating). Remain in FILL.
    - Accepted beat with idx==NUM_PIXELS-1 and in_last=0 (long frame): frame dropped, err_pulse, drop_count += 1, go to DISCARD.
  - DISCARD: in_ready=1. Beats are accepted and ignored until a beat with in_last=1 is accepted, then idx=0 and return to FILL. No further drop is counted for the same frame.
- Read side:
  - out_valid = read bank full; out_data = contents of the read bank.
  - out_valid && out_ready: read bank marked empty, rd_bank toggles, frame_count += 1.
  - out_data holds its value while out_valid=1 && out_ready=0.
- Latency: the beat completing a frame is accepted at edge t; out_valid=1 from t+1 when the read bank was empty. Peak throughput is one pixel per cycle with no bubbles between frames while a bank is free.
- Backpressure: if both banks are full, in_ready=0 in FILL. When a consume and a frame completion occur on the same edge, the freed bank is usable next cycle.
- Simultaneous completion and consumption on different banks: both bank-state updates apply on the same edge.
- Stale bits: bank bits are not cleared on drop; every bit is rewritten before a bank can be marked full.
- Reset mid-frame: any partial frame and any full banks are discarded. Counters clear.
- out_data is registered; no combinational path from in_* to out_*.

Test Plan:
- NUM_PIXELS=16, THRESH=128. Stream pixels alternating 127,128 with in_last on the 16th beat, out_ready=1 -> out_valid one cycle after the last beat, out_data=16'hAAAA, frame_count=1.
- out_ready=0. Send 3 back-to-back valid frames -> first two fill both banks, in_ready drops after the second last-beat, third frame is stalled. Raise out_ready -> frames delivered in order, third completes, frame_count=3, no drops.
- Short frame: in_last on beat 10 -> err_pulse one cycle, drop_count=1, no out_valid. The next well-formed frame is delivered correctly.
- Long frame: 20 beats, in_last on beat 20 -> drop_count=1, beats 17-20 discarded. The following 16-beat frame is delivered with correct data.
- Assert rst on beat 8 of a frame with one bank full -> out_valid=0, frame_count=0, drop_count=0 immediately. The next full frame is delivered as normal.
- Force 300 short frames -> drop_count saturates at 255 while err_pulse still fires for each dropped frame.

Source files
------------

// File: rtl/mnist_s_pixel_frame_buffer.sv
// Pixel binarizer and ping-pong frame buffer feeding the mnist_s layer-0 LUTs.
// Serial 8-bit pixels are thresholded and packed into two alternating frame banks.
module mnist_s_pixel_frame_buffer #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int THRESH     = 128,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_PIXELS-1:0] out_data,
  output logic [CNT_W-1:0]      frame_count,
  output logic [7:0]            drop_count,
  output logic                  err_pulse
);

  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;

  function automatic logic binarize(input logic [PIX_W-1:0] pix);
    return (pix >= PIX_W'(THRESH));
  endfunction

  wr_state_t             state_r, state_nxt_s;
  logic [NUM_PIXELS-1:0] bank_r [2];
  logic [1:0]            full_r, full_nxt_s;
  logic                  wr_bank_r, wr_bank_nxt_s;
  logic                  rd_bank_r, rd_bank_nxt_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic                  ready_s, accept_s, consume_s, bit_we_s, drop_s;
  logic [CNT_W-1:0]      frame_count_r;
  logic [7:0]            drop_count_r;
  logic                  err_pulse_r;

  // Write-side readiness: a free write bank in FILL, always ready while discarding
  always_comb begin
    ready_s = 1'b1;
    if (state_r == FILL) begin
      ready_s = ~full_r[wr_bank_r];
    end else begin
      ready_s = 1'b1;
    end
  end

  assign accept_s  = in_valid & ready_s;
  assign consume_s = full_r[rd_bank_r] & out_ready;

  // Write FSM next state plus bank bookkeeping; consume and completion always hit different banks
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    full_nxt_s    = full_r;
    wr_bank_nxt_s = wr_bank_r;
    rd_bank_nxt_s = rd_bank_r;
    bit_we_s      = 1'b0;
    drop_s        = 1'b0;

    if (consume_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
      rd_bank_nxt_s         = ~rd_bank_r;
    end else begin
      rd_bank_nxt_s = rd_bank_r;
    end

    case (state_r)
      FILL: begin
        if (accept_s) begin
          bit_we_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s = {IDX_W{1'b0}};
            if (in_last) begin
              full_nxt_s[wr_bank_r] = 1'b1;
              wr_bank_nxt_s         = ~wr_bank_r;
            end else begin
              drop_s      = 1'b1;
              state_nxt_s = DISCARD;
            end
          end else if (in_last) begin
            drop_s    = 1'b1;
            idx_nxt_s = {IDX_W{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DISCARD: begin
        if (accept_s && in_last) begin
          state_nxt_s = FILL;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: begin
        state_nxt_s = FILL;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Control state, bank flags and status counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FILL;
      idx_r         <= {IDX_W{1'b0}};
      full_r        <= 2'b00;
      wr_bank_r     <= 1'b0;
      rd_bank_r     <= 1'b0;
      frame_count_r <= {CNT_W{1'b0}};
      drop_count_r  <= 8'd0;
      err_pulse_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      full_r      <= full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      err_pulse_r <= drop_s;
      if (consume_s) begin
        frame_count_r <= frame_count_r + CNT_W'(1);
      end
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  // Bank storage; dropped frames leave stale bits that a full frame always overwrites
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r[0] <= {NUM_PIXELS{1'b0}};
      bank_r[1] <= {NUM_PIXELS{1'b0}};
    end else if (bit_we_s) begin
      bank_r[wr_bank_r][idx_r] <= binarize(in_pixel);
    end
  end

  assign in_ready    = ready_s;
  assign out_valid   = full_r[rd_bank_r];
  assign out_data    = bank_r[rd_bank_r];
  assign frame_count = frame_count_r;
  assign drop_count  = drop_count_r;
  assign err_pulse   = err_pulse_r;

endmodule

// File: tb/tb_mnist_s_pixel_frame_buffer.sv
// Directed self-checking bench for mnist_s_pixel_frame_buffer with 16-pixel frames.
module tb_mnist_s_pixel_frame_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic        err_pulse;

  int tests;
  int fails;
  int err_cnt;
  int err_base;

  mnist_s_pixel_frame_buffer #(
    .NUM_PIXELS(16),
    .PIX_W(8),
    .THRESH(128),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_pixel = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_beat(input logic [7:0] pix, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // pattern bit i chooses 128 (binarizes to 1) or 127 (to 0); beats past 16 send 255
  task automatic send_frame(input logic [15:0] pat, input int nbeats, input logic last_en);
    logic [7:0] pix;
    for (int i = 0; i < nbeats; i++) begin
      if (i >= 16) pix = 8'd255;
      else if (pat[i]) pix = 8'd128;
      else pix = 8'd127;
      send_beat(pix, last_en && (i == nbeats - 1));
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    err_cnt   = 0;
    out_ready = 1'b1;
    do_reset();

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);

    // basic frame, threshold boundary 127/128
    send_frame(16'hAAAA, 16, 1'b1);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data", {16'd0, out_data}, 32'h0000AAAA);
    @(negedge clk);
    check("t1_frame_count", {16'd0, frame_count}, 32'd1);
    check("t1_out_valid_after", {31'd0, out_valid}, 32'd0);

    // backpressure: two banks fill, third frame stalls
    do_reset();
    out_ready = 1'b0;
    send_frame(16'h1111, 16, 1'b1);
    send_frame(16'h2222, 16, 1'b1);
    check("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("t2_hold_data", {16'd0, out_data}, 32'h00001111);
    fork
      send_frame(16'h3333, 16, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("t2_stalled", {31'd0, in_ready}, 32'd0);
        check("t2_still_a", {16'd0, out_data}, 32'h00001111);
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_b_valid", {31'd0, out_valid}, 32'd1);
        check("t2_b_data", {16'd0, out_data}, 32'h00002222);
        @(negedge clk);
        wait_out_valid("t2_c_timeout");
        check("t2_c_data", {16'd0, out_data}, 32'h00003333);
        @(negedge clk);
        check("t2_frame_count", {16'd0, frame_count}, 32'd3);
        check("t2_drop_count", {24'd0, drop_count}, 32'd0);
      end
    join

    // short frame
    do_reset();
    err_base = err_cnt;
    send_frame(16'hFFFF, 10, 1'b1);
    check("t3_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("t3_drop_count", {24'd0, drop_count}, 32'd1);
    @(negedge clk);
    check("t3_err_pulse_off", {31'd0, err_pulse}, 32'd0);
    check("t3_no_valid", {31'd0, out_valid}, 32'd0);
    check("t3_err_cnt", err_cnt - err_base, 32'd1);
    send_frame(16'h1234, 16, 1'b1);
    check("t3_next_valid", {31'd0, out_valid}, 32'd1);
    check("t3_next_data", {16'd0, out_data}, 32'h00001234);

    // long frame
    do_reset();
    err_base = err_cnt;
    send_frame(16'hFFFF, 20, 1'b1);
    @(negedge clk);
    check("t4_drop_count", {24'd0, drop_count}, 32'd1);
    check("t4_err_cnt", err_cnt - err_base, 32'd1);
    check("t4_no_valid", {31'd0, out_valid}, 32'd0);
    send_frame(16'h0F0F, 16, 1'b1);
    check("t4_next_valid", {31'd0, out_valid}, 32'd1);
    check("t4_next_data", {16'd0, out_data}, 32'h00000F0F);
    @(negedge clk);
    check("t4_frame_count", {16'd0, frame_count}, 32'd1);

    // reset mid-frame with one bank full
    do_reset();
    send_frame(16'h00FF, 16, 1'b1);
    @(negedge clk);
    send_frame(16'h0000, 4, 1'b1);
    out_ready = 1'b0;
    send_frame(16'h5555, 16, 1'b1);
    send_frame(16'h0000, 7, 1'b0);
    check("t5_pre_frame_count", {16'd0, frame_count}, 32'd1);
    check("t5_pre_drop_count", {24'd0, drop_count}, 32'd1);
    check("t5_pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_pixel = 8'd200;
    rst      = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("t5_rst_drop_count", {24'd0, drop_count}, 32'd0);
    check("t5_rst_out_data", {16'd0, out_data}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send_frame(16'hC3C3, 16, 1'b1);
    check("t5_next_valid", {31'd0, out_valid}, 32'd1);
    check("t5_next_data", {16'd0, out_data}, 32'h0000C3C3);
    @(negedge clk);
    check("t5_frame_count", {16'd0, frame_count}, 32'd1);

    // drop counter saturation
    do_reset();
    err_base = err_cnt;
    for (int k = 0; k < 300; k++) send_frame(16'h0000, 1, 1'b1);
    @(negedge clk);
    check("t6_drop_sat", {24'd0, drop_count}, 32'd255);
    check("t6_err_cnt", err_cnt - err_base, 32'd300);
    check("t6_no_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
